cache_ctrl_dm: RTL and testbench
================================

// Module: cache_ctrl_dm
// PURPOSE
//  Direct-mapped, read-only (instruction) cache controller placed between the
//  monocycle fetch stage and the backing word memory. Hits return data in the
//  request cycle; misses stall the CPU and refill one whole line from memory.
//  The memory read port is combinational: data arrives in the same cycle as the address.
// PARAMETERS
//  ANCHO       32  data word width
//  PROF        10  word-address width, shared with the backing memory
//  LINES_LOG2   4  log2 number of cache lines (16)
//  WORDS_LOG2   2  log2 words per line (4); TAG_W = PROF-LINES_LOG2-WORDS_LOG2 (4)
// PORTS
//  clk_i         in   1      clock, rising edge
//  rst_i         in   1      reset, synchronous, active-high
//  req_i         in   1      CPU read request
//  addr_i        in   PROF   CPU word address
//  flush_i       in   1      invalidate all lines
//  rdy_o         out  1      data_o valid this cycle
//  data_o        out  ANCHO  read data; 0 when rdy_o=0
//  stall_o       out  1      CPU must hold req_i/addr_i
//  mem_rden_o    out  1      memory read enable
//  mem_rdaddr_o  out  PROF   memory word address
//  mem_rddata_i  in   ANCHO  memory data, same cycle as mem_rdaddr_o
//  hit_cnt_o     out  32     hit counter (CACHE_STATS_EN only)
//  miss_cnt_o    out  32     miss counter (CACHE_STATS_EN only)
// BEHAVIOUR
//  - Address split: off=addr[WORDS_LOG2-1:0], idx=next LINES_LOG2 bits,
//    tag=upper TAG_W bits. Storage: valid[], tag[], and a data array of 2**(LINES_LOG2+WORDS_LOG2) words.
//  - Reset: state=IDLE; all valid=0; flush_pend=0. Outputs rdy_o=0, stall_o=0,
//    mem_rden_o=0, mem_rdaddr_o=0, data_o=0, counters=0.
//    Tag/data arrays are not reset.
//  - FSM states: IDLE, REFILL, RESP.
//  - IDLE, req_i=1 and hit (valid[idx] and tag match): combinational rdy_o=1,
//    data_o=word; stall_o=0; mem_rden_o=0. Latency 0 cycles.
//  - IDLE, req_i=1 and miss: stall_o=1 in the same cycle; register addr_i into
//    miss_addr; cnt=0; go to REFILL.
//  - REFILL: stall_o=1, mem_rden_o=1, mem_rdaddr_o={miss tag,idx,cnt}.
//    On each edge, write mem_rddata_i into the data array and increment cnt.
//    After the last word (cnt=2**WORDS_LOG2-1), set valid/tag and go to RESP.
//  - RESP: rdy_o=1, stall_o=0, data_o=word at miss_addr; go to IDLE.
//    Miss latency with defaults: rdy_o is high 5 cycles after the miss cycle
//    (miss cycle 0, refill cycles 1-4, RESP cycle 5).
//  - addr_i/req_i changes during REFILL/RESP are ignored; miss_addr is used.
//  - flush_i in IDLE: clear all valid bits at the next edge. It has priority
//    over a same-cycle req_i: that cycle has rdy_o=0, stall_o=1, and the request
//    is re-evaluated next cycle.
//  - flush_i in REFILL/RESP: set flush_pend. On entry to IDLE, the pending
//    flush is applied before any lookup (one cycle, with stall_o=1 if req_i=1).
//  - valid is written only at the end of a refill. A reset mid-refill leaves the
//    line invalid and returns to IDLE next cycle.
//  - Index wrap: offset counter wraps only inside the line; no cross-line fetch.
// CONFIGURATION
//  CACHE_STATS_EN defined:
//   - hit_cnt_o increments on each IDLE hit cycle; miss_cnt_o on each miss
//     detection.
//   - Both are 32-bit, wrap at 2**32, and clear on rst_i only (not on flush).
//  CACHE_STATS_EN undefined: the counter ports and logic are absent.
// TESTING
//  1. rst_i, then req 0x000 -> stall_o=1 cycles 0-4; mem_rdaddr_o 0,1,2,3 in
//     cycles 1-4; cycle 5 rdy_o=1, data_o=mem[0].
//  2. Then req 0x002 -> same-cycle rdy_o=1, data_o=mem[2], mem_rden_o=0.
//  3. req 0x040 (idx 0, tag 1) -> miss, refills 0x040-0x043; then req 0x000
//     -> misses again (evicted).
//  4. flush_i one cycle in IDLE, then req 0x041 -> miss. Also: flush_i during
//     REFILL -> after RESP a one-cycle flush, and a repeat of the same address misses.
//  5. rst_i during refill cycle 2 -> next cycle all outputs at reset values;
//     req 0x000 then misses (line left invalid).
//  6. With CACHE_STATS_EN, run 1-3 -> hit_cnt_o=1, miss_cnt_o=3.

Source files
------------

// File: rtl/cache_ctrl_dm.sv
// rtl/cache_ctrl_dm.sv - direct-mapped read-only instruction cache controller with line refill
// Optional hit/miss statistics counters are built when CACHE_STATS_EN is defined.
module cache_ctrl_dm #(
  parameter int ANCHO      = 32,
  parameter int PROF       = 10,
  parameter int LINES_LOG2 = 4,
  parameter int WORDS_LOG2 = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic [PROF-1:0]  addr_i,
  input  logic             flush_i,
  output logic             rdy_o,
  output logic [ANCHO-1:0] data_o,
  output logic             stall_o,
  output logic             mem_rden_o,
  output logic [PROF-1:0]  mem_rdaddr_o,
  input  logic [ANCHO-1:0] mem_rddata_i
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]      hit_cnt_o,
  output logic [31:0]      miss_cnt_o
`endif
);

  localparam int TAG_W  = PROF - LINES_LOG2 - WORDS_LOG2;
  localparam int NLINES = 2 ** LINES_LOG2;
  localparam int DEPTH  = 2 ** (LINES_LOG2 + WORDS_LOG2);
  localparam int IW     = LINES_LOG2 + WORDS_LOG2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REFILL = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]            state;
  logic [NLINES-1:0]     valid;
  logic [TAG_W-1:0]      tags [NLINES];
  logic [ANCHO-1:0]      data_mem [DEPTH];
  logic [PROF-1:0]       miss_addr;
  logic [WORDS_LOG2-1:0] cnt;
  logic                  flush_pend;

  logic [LINES_LOG2-1:0] req_idx, miss_idx;
  logic [TAG_W-1:0]      req_tag, miss_tag;
  logic                  hit, do_flush, lookup_hit, lookup_miss, refill_last;

  assign req_idx     = addr_i[WORDS_LOG2 +: LINES_LOG2];
  assign req_tag     = addr_i[PROF-1 -: TAG_W];
  assign miss_idx    = miss_addr[WORDS_LOG2 +: LINES_LOG2];
  assign miss_tag    = miss_addr[PROF-1 -: TAG_W];
  assign hit         = valid[req_idx] && (tags[req_idx] == req_tag);
  // A flush (fresh or deferred from a refill) owns the IDLE cycle; lookups wait.
  assign do_flush    = (state == S_IDLE) && (flush_i || flush_pend);
  assign lookup_hit  = (state == S_IDLE) && !do_flush && req_i && hit;
  assign lookup_miss = (state == S_IDLE) && !do_flush && req_i && !hit;
  assign refill_last = (state == S_REFILL) && (cnt == '1);

  always_comb begin
    rdy_o        = 1'b0;
    data_o       = '0;
    stall_o      = 1'b0;
    mem_rden_o   = 1'b0;
    mem_rdaddr_o = '0;
    case (state)
      S_IDLE: begin
        if (do_flush) begin
          stall_o = req_i;
        end else if (lookup_hit) begin
          rdy_o  = 1'b1;
          data_o = data_mem[addr_i[IW-1:0]];
        end else if (lookup_miss) begin
          stall_o = 1'b1;
        end
      end
      S_REFILL: begin
        stall_o      = 1'b1;
        mem_rden_o   = 1'b1;
        mem_rdaddr_o = {miss_tag, miss_idx, cnt};
      end
      S_RESP: begin
        rdy_o  = 1'b1;
        data_o = data_mem[miss_addr[IW-1:0]];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      valid      <= '0;
      flush_pend <= 1'b0;
      miss_addr  <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (do_flush) begin
            valid      <= '0;
            flush_pend <= 1'b0;
          end else if (lookup_miss) begin
            miss_addr <= addr_i;
            cnt       <= '0;
            state     <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (flush_i) flush_pend <= 1'b1;
          cnt <= cnt + 1'b1;
          if (refill_last) begin
            valid[miss_idx] <= 1'b1;
            state           <= S_RESP;
          end
        end
        S_RESP: begin
          if (flush_i) flush_pend <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Tag and data storage carry no reset; valid bits alone qualify them.
  always_ff @(posedge clk_i) begin
    if (!rst_i && state == S_REFILL) begin
      data_mem[{miss_idx, cnt}] <= mem_rddata_i;
      if (refill_last) tags[miss_idx] <= miss_tag;
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (lookup_hit)  hit_cnt_o  <= hit_cnt_o + 32'd1;
      if (lookup_miss) miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_ctrl_dm.sv
// tb/tb_cache_ctrl_dm.sv - self-checking bench for cache_ctrl_dm against a line-residency model
// Counter checks are compiled when CACHE_STATS_EN is defined.
module tb_cache_ctrl_dm;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic [9:0]  addr = '0;
  logic        flush = 1'b0;
  logic        rdy, stall, mem_rden;
  logic [31:0] data, mem_rddata;
  logic [9:0]  mem_rdaddr;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  logic [31:0] mem [0:1023];
  int          line_of [16];
  int          pass_cnt = 0;
  int          total_cnt = 0;

  always #5 clk = ~clk;
  assign mem_rddata = mem[mem_rdaddr];

  cache_ctrl_dm dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .flush_i(flush),
    .rdy_o(rdy), .data_o(data), .stall_o(stall), .mem_rden_o(mem_rden),
    .mem_rdaddr_o(mem_rdaddr), .mem_rddata_i(mem_rddata)
`ifdef CACHE_STATS_EN
    , .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
`endif
  );

  task automatic model_clear();
    for (int i = 0; i < 16; i++) line_of[i] = -1;
  endtask

  // One request: hit answers in the request cycle, miss fetches the 4-word line and answers 5 cycles later.
  task automatic do_req(input logic [9:0] a);
    bit exp_hit;
    logic [9:0] base;
    exp_hit = (line_of[a[5:2]] == int'(a[9:2]));
    base = {a[9:2], 2'b00};
    @(posedge clk); #1;
    req = 1'b1; addr = a;
    @(negedge clk);
    total_cnt++;
    if (exp_hit) begin
      if ({rdy, stall, mem_rden, data} !== {1'b1, 1'b0, 1'b0, mem[a]})
        $display("FAIL hit_0x%03h got rdy=%0b stall=%0b rden=%0b data=%08h want 1 0 0 %08h",
                 a, rdy, stall, mem_rden, data, mem[a]);
      else pass_cnt++;
    end else begin
      if ({rdy, stall} !== 2'b01)
        $display("FAIL miss_cycle0_0x%03h got rdy=%0b stall=%0b want 0 1", a, rdy, stall);
      else pass_cnt++;
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #1;
        @(negedge clk);
        total_cnt++;
        if ({rdy, stall, mem_rden, mem_rdaddr} !== {1'b0, 1'b1, 1'b1, base + 10'(k)})
          $display("FAIL refill_0x%03h_c%0d got rdy=%0b stall=%0b rden=%0b maddr=%03h want 0 1 1 %03h",
                   a, k + 1, rdy, stall, mem_rden, mem_rdaddr, base + 10'(k));
        else pass_cnt++;
      end
      @(posedge clk); #1;
      @(negedge clk);
      total_cnt++;
      if ({rdy, stall, mem_rden, data} !== {1'b1, 1'b0, 1'b0, mem[a]})
        $display("FAIL resp_0x%03h got rdy=%0b stall=%0b rden=%0b data=%08h want 1 0 0 %08h",
                 a, rdy, stall, mem_rden, data, mem[a]);
      else pass_cnt++;
      line_of[a[5:2]] = int'(a[9:2]);
    end
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
    @(negedge clk);
    total_cnt++;
    if ({rdy, stall, mem_rden, mem_rdaddr, data} !== 45'd0)
      $display("FAIL reset_outputs got rdy=%0b stall=%0b rden=%0b maddr=%03h data=%08h want all 0",
               rdy, stall, mem_rden, mem_rdaddr, data);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    do_req(10'h000);
    do_req(10'h002);
  endtask

  task automatic test_evict();
    do_req(10'h040);
    do_req(10'h000);
  endtask

  task automatic test_stats();
`ifdef CACHE_STATS_EN
    @(negedge clk);
    total_cnt++;
    if ({hit_cnt, miss_cnt} !== {32'd1, 32'd3})
      $display("FAIL stats got hit=%0d miss=%0d want 1 3", hit_cnt, miss_cnt);
    else pass_cnt++;
`endif
  endtask

  task automatic test_flush_idle();
    do_req(10'h041);
    do_req(10'h041);
    @(posedge clk); #1;
    req = 1'b1; addr = 10'h041; flush = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({rdy, stall} !== 2'b01)
      $display("FAIL flush_idle got rdy=%0b stall=%0b want 0 1", rdy, stall);
    else pass_cnt++;
    @(posedge clk); #1;
    flush = 1'b0; req = 1'b0;
    model_clear();
    do_req(10'h041);
  endtask

  task automatic test_flush_refill();
    logic [9:0] a;
    a = 10'h085;
    @(posedge clk); #1;
    req = 1'b1; addr = a;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; addr = 10'h3ff;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    total_cnt++;
    if ({rdy, data} !== {1'b1, mem[a]})
      $display("FAIL flush_refill_resp got rdy=%0b data=%08h want 1 %08h", rdy, data, mem[a]);
    else pass_cnt++;
    @(posedge clk); #1;
    addr = a;
    @(negedge clk);
    total_cnt++;
    if ({rdy, stall} !== 2'b01)
      $display("FAIL pending_flush got rdy=%0b stall=%0b want 0 1", rdy, stall);
    else pass_cnt++;
    @(posedge clk); #1;
    req = 1'b0;
    model_clear();
    do_req(a);
  endtask

  task automatic test_reset_refill();
    @(posedge clk); #1;
    req = 1'b1; addr = 10'h0c0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({rdy, stall, mem_rden, mem_rdaddr, data} !== 45'd0)
      $display("FAIL reset_mid_refill got rdy=%0b stall=%0b rden=%0b maddr=%03h data=%08h want all 0",
               rdy, stall, mem_rden, mem_rdaddr, data);
    else pass_cnt++;
    model_clear();
    do_req(10'h000);
    do_req(10'h0c0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 11) == 0) begin
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({rdy, stall, mem_rden} !== 3'b000)
          $display("FAIL rand_flush got rdy=%0b stall=%0b rden=%0b want 0 0 0", rdy, stall, mem_rden);
        else pass_cnt++;
        @(posedge clk); #1;
        flush = 1'b0;
        model_clear();
      end else begin
        do_req(10'($urandom_range(0, 127)));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    model_clear();
    test_reset();
    test_basic();
    test_evict();
    test_stats();
    test_flush_idle();
    test_flush_refill();
    test_reset_refill();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
